// File: rtl/regbank_pkg.sv
// Shared constants and types for the configuration register bank and its
// two-port write arbiter.
package regbank_pkg;

  localparam int DEF_ADDR_W   = 7;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_ADDR = 4;

  // Storage exists for exactly five live registers (data0..data4).
  localparam int NUM_REGS = 5;

  localparam int REG_EN_OUT_LO = 0;
  localparam int REG_EN_OUT_HI = 1;
  localparam int REG_EN_PWM_LO = 2;
  localparam int REG_EN_PWM_HI = 3;
  localparam int REG_PWM_DUTY  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/regbank_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. On a tie the requester that did not win the
// previous grant is chosen. last_winner resets to B, so A wins the first tie.
// Grants are combinational and only asserted while i_en is high.
module rr_arbiter2
  import regbank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_grant_a,
  output logic o_grant_b
);

  logic r_last_b;

  // Combinational grant: a lone requester wins, a tie goes to the non-last winner.
  always_comb begin
    o_grant_a = i_en && i_req_a && (!i_req_b || r_last_b);
    o_grant_b = i_en && i_req_b && (!i_req_a || !r_last_b);
  end

  // Remember who won the most recent grant; a grant is always a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (o_grant_a || o_grant_b) begin
      r_last_b <= o_grant_b;
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Configuration register bank (five 8-bit registers) with a two-requester
// write arbiter. Port A is the SPI frame decoder, port B the configuration
// sequencer / debug path.
//
// Handshake: a requester holds valid/addr/data stable until it sees ready.
// ready is combinational, asserted only in IDLE and only for the granted
// requester; valid && ready is the transfer. The following cycle is WRITE
// (busy=1, both ready low), so at most one write every two cycles.
//
// Optional build macro: REGBANK_SHADOW_EN. When defined, WRITE updates a
// shadow copy and data0..data4 load from the shadow on any cycle with commit=1.
// When undefined, commit is ignored and WRITE updates data0..data4 directly.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_ADDR = DEF_MAX_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              commit,
  output logic              busy,
  output logic              err,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] data3,
  output logic [DATA_W-1:0] data4,
  output state_t            o_dbg_state,
  output logic              o_dbg_winner_b
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_winner_b;
  logic              r_busy;
  logic              r_err;
  logic [DATA_W-1:0] r_live [NUM_REGS];

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_hs;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_wr_en;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_state == ST_IDLE),
    .i_req_a   (a_valid),
    .i_req_b   (b_valid),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b)
  );

  // Select the winning requester's payload and qualify the register write.
  always_comb begin
    w_hs       = w_grant_a || w_grant_b;
    w_sel_addr = w_grant_b ? b_addr : a_addr;
    w_sel_data = w_grant_b ? b_data : a_data;
    // Full-width unsigned compare so aliases like 0x44 are rejected.
    w_wr_en    = (r_state == ST_WRITE) && (r_addr <= ADDR_W'(MAX_ADDR));
  end

  assign a_ready        = w_grant_a;
  assign b_ready        = w_grant_b;
  assign busy           = r_busy;
  assign err            = r_err;
  assign o_dbg_state    = r_state;
  assign o_dbg_winner_b = r_winner_b;

  // Two-state FSM: latch the accepted request in IDLE, spend one WRITE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_winner_b <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_addr     <= w_sel_addr;
            r_data     <= w_sel_data;
            r_winner_b <= w_grant_b;
            r_busy     <= 1'b1;
            r_err      <= (w_sel_addr > ADDR_W'(MAX_ADDR));
            r_state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef REGBANK_SHADOW_EN
  logic [DATA_W-1:0] r_shadow [NUM_REGS];

  // WRITE lands in the shadow copy only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_en && (r_addr == ADDR_W'(i))) r_shadow[i] <= r_data;
      end
    end
  end

  // commit copies the shadow as it stood before this edge, so a write in
  // the same cycle waits for the next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_live[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) r_live[i] <= r_shadow[i];
    end
  end
`else
  logic w_unused_commit;
  assign w_unused_commit = commit;

  // WRITE updates the live registers directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_live[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_en && (r_addr == ADDR_W'(i))) r_live[i] <= r_data;
      end
    end
  end
`endif

  assign data0 = r_live[REG_EN_OUT_LO];
  assign data1 = r_live[REG_EN_OUT_HI];
  assign data2 = r_live[REG_EN_PWM_LO];
  assign data3 = r_live[REG_EN_PWM_HI];
  assign data4 = r_live[REG_PWM_DUTY];

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter. Inputs change 1ns after the
// rising edge; outputs are checked 1-2ns after the edge.
module tb_regbank_write_arbiter;
  import regbank_pkg::*;

  logic       clk;
  logic       rst;
  logic       a_valid, b_valid, commit;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, busy, err;
  logic [7:0] data0, data1, data2, data3, data4;
  state_t     dbg_state;
  logic       dbg_winner_b;

  int checks = 0;
  int errors = 0;

  regbank_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .commit(commit), .busy(busy), .err(err),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3), .data4(data4),
    .o_dbg_state(dbg_state), .o_dbg_winner_b(dbg_winner_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; commit = 1'b0;
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Driver: one A write with full handshake and WRITE cycle.
  task automatic drive_a(input logic [6:0] addr, input logic [7:0] data);
    a_valid = 1'b1; a_addr = addr; a_data = data;
    #1;
    step();
    a_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    checks++; if ({data0, data1, data2, data3, data4} !== 40'h0) begin errors++;
      $display("FAIL reset_data: got %h exp 0", {data0, data1, data2, data3, data4}); end
    checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b exp 00", {a_ready, b_ready}); end
  endtask

  task automatic test_single_write();
    apply_reset();
    a_valid = 1'b1; a_addr = 7'd4; a_data = 8'h80;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b exp 10", {a_ready, b_ready}); end
    step();
    a_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", busy); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL single_ready_wr: got %b exp 0", a_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b exp 0", err); end
    checks++; if (data4 !== 8'h00) begin errors++; $display("FAIL single_data4_early: got %h exp 00", data4); end
    step();
    checks++; if (data4 !== 8'h80) begin errors++; $display("FAIL single_data4: got %h exp 80", data4); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b exp 0", busy); end
  endtask

  task automatic test_tie();
    apply_reset();
    a_valid = 1'b1; a_addr = 7'd0; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 7'd1; b_data = 8'h22;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL tie_first: got %b exp 10", {a_ready, b_ready}); end
    step();
    a_valid = 1'b0;
    #1;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL tie_b_stall: got %b exp 0", b_ready); end
    step();
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL tie_b_grant: got %b exp 1", b_ready); end
    checks++; if (data0 !== 8'h11) begin errors++; $display("FAIL tie_data0: got %h exp 11", data0); end
    step();
    b_valid = 1'b0;
    step();
    checks++; if (data1 !== 8'h22) begin errors++; $display("FAIL tie_data1: got %h exp 22", data1); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy;
    apply_reset();
    a_valid = 1'b1; a_addr = 7'd2;
    b_valid = 1'b1; b_addr = 7'd3;
    for (int k = 0; k < 6; k++) begin
      a_data = 8'hA0 + 8'(k);
      b_data = 8'hB0 + 8'(k);
      exp_rdy = (k % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      checks++; if ({a_ready, b_ready} !== exp_rdy) begin errors++;
        $display("FAIL b2b_grant_%0d: got %b exp %b", k, {a_ready, b_ready}, exp_rdy); end
      step();
      checks++; if (dbg_winner_b !== exp_rdy[0]) begin errors++;
        $display("FAIL b2b_winner_%0d: got %b exp %b", k, dbg_winner_b, exp_rdy[0]); end
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    checks++; if (data2 !== 8'hA4) begin errors++; $display("FAIL b2b_data2: got %h exp a4", data2); end
    checks++; if (data3 !== 8'hB5) begin errors++; $display("FAIL b2b_data3: got %h exp b5", data3); end
  endtask

  task automatic test_bad_addr();
    logic [6:0] bad [2];
    bad[0] = 7'd5;
    bad[1] = 7'h44;
    apply_reset();
    drive_a(7'd0, 8'h33);
    for (int k = 0; k < 2; k++) begin
      b_valid = 1'b1; b_addr = bad[k]; b_data = 8'hFF;
      #1;
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL bad_ready_%0d: got %b exp 1", k, b_ready); end
      step();
      b_valid = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err_%0d: got %b exp 1", k, err); end
      step();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_clear_%0d: got %b exp 0", k, err); end
      checks++; if ({data0, data1, data2, data3, data4} !== 40'h33_00_00_00_00) begin errors++;
        $display("FAIL bad_data_%0d: got %h exp 3300000000", k, {data0, data1, data2, data3, data4}); end
    end
  endtask

  task automatic test_reset_in_write();
    apply_reset();
    drive_a(7'd1, 8'h77);
    a_valid = 1'b1; a_addr = 7'd2; a_data = 8'h5A;
    #1;
    step();
    a_valid = 1'b0;
    rst = 1'b1;
    checks++; if (dbg_state !== ST_WRITE) begin errors++; $display("FAIL rstw_in_write: got %0d exp 1", dbg_state); end
    step();
    rst = 1'b0;
    checks++; if (data2 !== 8'h00) begin errors++; $display("FAIL rstw_data2: got %h exp 00", data2); end
    checks++; if (data1 !== 8'h00) begin errors++; $display("FAIL rstw_data1: got %h exp 00", data1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %b exp 0", busy); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstw_state: got %0d exp 0", dbg_state); end
    step();
    checks++; if (data2 !== 8'h00) begin errors++; $display("FAIL rstw_data2_late: got %h exp 00", data2); end
  endtask

`ifdef REGBANK_SHADOW_EN
  task automatic test_shadow();
    apply_reset();
    drive_a(7'd3, 8'h0F);
    checks++; if (data3 !== 8'h00) begin errors++; $display("FAIL shd_nocommit: got %h exp 00", data3); end
    commit = 1'b1;
    step();
    commit = 1'b0;
    checks++; if (data3 !== 8'h0F) begin errors++; $display("FAIL shd_commit: got %h exp 0f", data3); end
    a_valid = 1'b1; a_addr = 7'd3; a_data = 8'hF0;
    #1;
    step();
    a_valid = 1'b0;
    commit = 1'b1;
    step();
    commit = 1'b0;
    checks++; if (data3 !== 8'h0F) begin errors++; $display("FAIL shd_coincident: got %h exp 0f", data3); end
    step();
    checks++; if (data3 !== 8'h0F) begin errors++; $display("FAIL shd_hold: got %h exp 0f", data3); end
    commit = 1'b1;
    step();
    commit = 1'b0;
    checks++; if (data3 !== 8'hF0) begin errors++; $display("FAIL shd_commit2: got %h exp f0", data3); end
  endtask
`else
  task automatic test_commit_ignored();
    apply_reset();
    commit = 1'b1;
    drive_a(7'd3, 8'h0F);
    checks++; if (data3 !== 8'h0F) begin errors++; $display("FAIL direct_data3: got %h exp 0f", data3); end
    commit = 1'b0;
    drive_a(7'd3, 8'hF0);
    checks++; if (data3 !== 8'hF0) begin errors++; $display("FAIL direct_data3_nc: got %h exp f0", data3); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_back_to_back();
    test_bad_addr();
    test_reset_in_write();
`ifdef REGBANK_SHADOW_EN
    test_shadow();
`else
    test_commit_ignored();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
